instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end fetch stage of the MIPS processor. It generates `read_address` for the synchronous InstructionMemory, tracks the in-flight word, and hands fetched instructions with their PC to decode. Decode can stall it; branch and jump resolution can redirect it. It also keeps fetch and stall performance counters.

## Interface
- RESET_PC, 32'h0000_0000: first address fetched after reset.
- clock  in  1  rising-edge clock, shared with InstructionMemory.
- reset  in  1  asynchronous, active-high.
- stall  in  1  decode cannot accept a new word; hold the `if_*` outputs.
- redirect_valid  in  1  redirect fetch to `redirect_target`; flush the current output.
- redirect_target  in  32  new PC; bits [1:0] ignored (treated as 0).
- instruction  in  32  InstructionMemory output; holds the word at the address latched at the previous clock edge.
- read_address  out  32  InstructionMemory address; combinational, see Operation.
- if_valid  out  1  `if_instruction`/`if_pc` hold a valid fetched word.
- if_instruction  out  32  fetched word.
- if_pc  out  32  address of `if_instruction`.
- fetch_count  out  32  number of words delivered to decode.
- stall_count  out  32  cycles a valid output was held by stall.

## Operation
- Internal registers:
  - fetch_pc: next address to request.
  - resp_valid, resp_pc: word currently on `instruction`, and its address.
  - Output registers: if_valid, if_pc, if_instruction.
  - The two counters.
- State decode:
  - IDLE: resp_valid = 0.
  - RUN: resp_valid = 1 and stall = 0.
  - STALL: resp_valid = 1 and stall = 1.
- read_address, in priority order:
  - redirect_valid: {redirect_target[31:2], 2'b00}.
  - else stall and resp_valid: resp_pc (replay the in-flight word so it is not lost).
  - else: fetch_pc.
- At each clock edge, redirect_valid (overrides stall):
  - if_valid ← 0.
  - resp_valid ← 1, resp_pc ← masked target.
  - fetch_pc ← masked target + 4.
  - Counters unchanged.
- At each clock edge, no redirect, stall = 0:
  - if_valid ← resp_valid, if_pc ← resp_pc, if_instruction ← instruction.
  - resp_valid ← 1, resp_pc ← fetch_pc, fetch_pc ← fetch_pc + 4.
  - fetch_count += 1 if resp_valid.
- At each clock edge, no redirect, stall = 1:
  - All PC, response and output registers hold.
  - stall_count += 1 if if_valid.
- Transitions:
  - IDLE → RUN on any edge with stall = 0 or redirect.
  - RUN → STALL when stall is asserted.
  - STALL → RUN when stall is released or on redirect.
  - IDLE with stall = 1 stays IDLE; the memory read of fetch_pc is harmless.
- Arithmetic:
  - All PC additions are 32-bit and wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0).
  - Counters wrap modulo 2^32.
- Reset, asynchronous, takes effect immediately even mid-stall or mid-redirect:
  - fetch_pc = RESET_PC, resp_valid = 0, resp_pc = 0.
  - if_valid = 0, if_pc = 0, if_instruction = 0, counters = 0.
  - read_address = RESET_PC.

## Timing
- Memory contract: address presented in cycle n appears on `instruction` in cycle n+1.
- Latency:
  - After reset deassert, first valid output 2 edges later.
  - After redirect, target word valid 2 edges after the redirect edge.
- Throughput: one word per cycle with no stall and no redirect.
- Stall:
  - Outputs are stable for every cycle stall is high.
  - The first post-release edge delivers the next sequential word: no skip, no duplicate.
- Combinational paths: stall, redirect_valid, redirect_target → read_address. No path from instruction to any output.

## Test plan
- Boot: RESET_PC = 0, memory M[a] = 0xA000_0000|a, release reset.
  - read_address sequence is 0, 4, 8 …
  - if_valid rises after the 2nd edge with if_pc = 0, if_instruction = 0xA000_0000, then one word per cycle.
- Stall: hold stall 3 cycles while if_pc = 0x08.
  - Outputs hold for those cycles; read_address = 0x0C throughout.
  - After release, if_pc = 0x0C, then 0x10.
  - stall_count = 3; fetch_count does not advance during the stall.
- Redirect: redirect_valid with target 0x40 in the cycle if_pc = 0x10.
  - read_address = 0x40 that cycle.
  - Next cycle if_valid = 0, then if_pc = 0x40, 0x44.
- Redirect during stall, plus masking:
  - stall = 1 and redirect to 0x43 together → redirect wins; read_address = 0x40, then if_pc = 0x40.
  - Redirect to 0xFFFF_FFFC → if_pc sequence is 0xFFFF_FFFC, 0x0.
- Async reset mid-stall:
  - Assert reset between clock edges → if_valid = 0, counters = 0 and read_address = RESET_PC immediately, before the next edge.
  - Normal boot sequence resumes after release.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: drives the synchronous instruction memory
// address, tracks the word currently in flight, and hands fetched words with
// their PC to decode. Decode can stall the stage and branch/jump resolution
// can redirect it. Also counts delivered words and stalled cycles.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic [31:0] instruction,
   output logic [31:0] read_address,
   output logic        if_valid,
   output logic [31:0] if_instruction,
   output logic [31:0] if_pc,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      STALL
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] fetch_pc_q;
   logic [31:0] resp_pc_q;
   logic [31:0] target_pc;
   logic        resp_valid;
   logic        unused_target_bits;

   // Word-aligned redirect target; the low two bits never select an address.
   assign target_pc          = {redirect_target[31:2], 2'b00};
   assign unused_target_bits = ^redirect_target[1:0];

   // A word is in flight on the memory output whenever we have left IDLE.
   assign resp_valid = (state_q != IDLE);

   // Memory address: redirect first, then replay the in-flight word while
   // stalled so it is still on the memory output when decode accepts it.
   assign read_address = redirect_valid ? target_pc :
                         (stall && resp_valid) ? resp_pc_q : fetch_pc_q;

   // Fetch state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: redirect always produces an in-flight word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (redirect_valid || !stall) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!redirect_valid && stall) begin
               state_d = STALL;
            end
         end
         STALL: begin
            if (redirect_valid || !stall) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // PC tracking and output registers; redirect flushes the output.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_pc_q     <= RESET_PC;
         resp_pc_q      <= 32'h0;
         if_valid       <= 1'b0;
         if_pc          <= 32'h0;
         if_instruction <= 32'h0;
      end else if (redirect_valid) begin
         if_valid   <= 1'b0;
         resp_pc_q  <= target_pc;
         fetch_pc_q <= target_pc + 32'd4;
      end else if (!stall) begin
         if_valid       <= resp_valid;
         if_pc          <= resp_pc_q;
         if_instruction <= instruction;
         resp_pc_q      <= fetch_pc_q;
         fetch_pc_q     <= fetch_pc_q + 32'd4;
      end
   end

   // Performance counters: words handed to decode and cycles held by stall.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_count <= 32'h0;
         stall_count <= 32'h0;
      end else if (!redirect_valid) begin
         if (!stall && resp_valid) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (stall && if_valid) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a behavioural synchronous memory
// returns 0xA000_0000 | address, a scoreboard queue holds the expected words
// and a monitor pops one per delivery; stalls, redirects and reset are
// checked directly from the stimulus.
module tb_instruction_fetch_unit;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] instruction;
   logic [31:0] read_address;
   logic        if_valid;
   logic [31:0] if_instruction;
   logic [31:0] if_pc;
   logic [31:0] fetch_count;
   logic [31:0] stall_count;

   int          compared   = 0;
   int          mismatched = 0;
   logic [63:0] expect_q[$];
   logic        deliver_edge;

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clock          (clock),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .instruction    (instruction),
      .read_address   (read_address),
      .if_valid       (if_valid),
      .if_instruction (if_instruction),
      .if_pc          (if_pc),
      .fetch_count    (fetch_count),
      .stall_count    (stall_count)
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Synchronous instruction memory: the word for the address presented at
   // an edge appears on the output after that edge.
   always @(posedge clock) begin
      instruction <= 32'hA000_0000 | read_address;
   end

   // Remember whether the last edge was one where a new word is handed on.
   always @(posedge clock) begin
      deliver_edge <= !reset && !stall && !redirect_valid;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic pushExpect(input logic [31:0] pc);
      expect_q.push_back({pc, 32'hA000_0000 | pc});
   endtask

   // Monitor: on every delivering edge with a valid output, pop and compare.
   always @(negedge clock) begin
      if (deliver_edge === 1'b1 && if_valid === 1'b1) begin
         if (expect_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL sb_unexpected: got pc %h with empty queue", if_pc);
         end else begin
            logic [63:0] exp_word;
            exp_word = expect_q.pop_front();
            checkOutput("sb_pc", if_pc, exp_word[63:32]);
            checkOutput("sb_instruction", if_instruction, exp_word[31:0]);
         end
      end
   end

   // Advance to just after the next rising edge.
   task automatic applyStimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clock);
         #2;
      end
   endtask

   initial begin
      reset           = 1'b1;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      deliver_edge    = 1'b0;
      #1;
      checkOutput("reset_if_valid", {31'h0, if_valid}, 32'h0);
      checkOutput("reset_read_address", read_address, 32'h0);
      checkOutput("reset_fetch_count", fetch_count, 32'h0);
      checkOutput("reset_stall_count", stall_count, 32'h0);

      // Boot: release reset between edges.
      applyStimulus(2);
      reset = 1'b0;
      pushExpect(32'h00);
      pushExpect(32'h04);
      pushExpect(32'h08);
      pushExpect(32'h0C);
      pushExpect(32'h10);
      #1;
      checkOutput("boot_addr0", read_address, 32'h00);
      applyStimulus(1);
      checkOutput("boot_addr1", read_address, 32'h04);
      checkOutput("boot_not_yet_valid", {31'h0, if_valid}, 32'h0);
      applyStimulus(1);
      checkOutput("boot_addr2", read_address, 32'h08);
      checkOutput("boot_first_valid", {31'h0, if_valid}, 32'h1);
      applyStimulus(2);
      checkOutput("pre_stall_pc", if_pc, 32'h08);

      // Stall three cycles while if_pc = 0x08.
      stall = 1'b1;
      #1;
      checkOutput("stall_replay_addr", read_address, 32'h0C);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1);
         checkOutput("stall_hold_pc", if_pc, 32'h08);
         checkOutput("stall_hold_instr", if_instruction, 32'hA000_0008);
         checkOutput("stall_addr", read_address, 32'h0C);
      end
      checkOutput("stall_count_3", stall_count, 32'd3);
      checkOutput("fetch_count_held", fetch_count, 32'd3);
      stall = 1'b0;
      applyStimulus(1);
      checkOutput("post_stall_pc", if_pc, 32'h0C);
      applyStimulus(1);
      checkOutput("post_stall_pc2", if_pc, 32'h10);
      checkOutput("fetch_count_5", fetch_count, 32'd5);

      // Redirect to 0x40 while if_pc = 0x10.
      redirect_valid  = 1'b1;
      redirect_target = 32'h40;
      pushExpect(32'h40);
      pushExpect(32'h44);
      pushExpect(32'h48);
      #1;
      checkOutput("redirect_addr", read_address, 32'h40);
      applyStimulus(1);
      redirect_valid = 1'b0;
      checkOutput("redirect_flush", {31'h0, if_valid}, 32'h0);
      checkOutput("redirect_fetch_count", fetch_count, 32'd5);
      applyStimulus(3);
      checkOutput("redirect_seq_end", if_pc, 32'h48);

      // Stall and redirect to an unaligned target together.
      stall           = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h43;
      pushExpect(32'h40);
      pushExpect(32'h44);
      #1;
      checkOutput("masked_redirect_addr", read_address, 32'h40);
      applyStimulus(1);
      stall          = 1'b0;
      redirect_valid = 1'b0;
      checkOutput("masked_redirect_flush", {31'h0, if_valid}, 32'h0);
      applyStimulus(2);
      checkOutput("masked_seq_end", if_pc, 32'h44);

      // Redirect to the top of the address space; the PC wraps to zero.
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      pushExpect(32'hFFFF_FFFC);
      pushExpect(32'h0000_0000);
      applyStimulus(1);
      redirect_valid = 1'b0;
      applyStimulus(2);
      checkOutput("wrap_pc", if_pc, 32'h0);
      checkOutput("fetch_count_12", fetch_count, 32'd12);

      // Stall one cycle, then assert reset between edges.
      stall = 1'b1;
      applyStimulus(1);
      checkOutput("stall_count_4", stall_count, 32'd4);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("async_if_valid", {31'h0, if_valid}, 32'h0);
      checkOutput("async_read_address", read_address, 32'h0);
      checkOutput("async_fetch_count", fetch_count, 32'h0);
      checkOutput("async_stall_count", stall_count, 32'h0);
      applyStimulus(1);
      reset = 1'b0;
      stall = 1'b0;
      pushExpect(32'h00);
      pushExpect(32'h04);
      pushExpect(32'h08);
      applyStimulus(4);
      checkOutput("reboot_pc", if_pc, 32'h08);
      checkOutput("reboot_fetch_count", fetch_count, 32'd3);
      applyStimulus(1);
      checkOutput("sb_drained", expect_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
